// File: rtl/sync_fifo_lvl.sv
// Parametrised synchronous FIFO with registered fill level, programmable
// almost-full/almost-empty thresholds, sticky error flags, flush and optional output register.
module sync_fifo_lvl #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 3,
    parameter int OUT_REG   = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 w_en,
    input  logic [DATAWIDTH-1:0] DataIn,
    input  logic                 r_en,
    output logic [DATAWIDTH-1:0] DataOut,
    output logic                 full,
    output logic                 empty,
    output logic [ADDRWIDTH:0]   level,
    input  logic [ADDRWIDTH:0]   afull_thr,
    input  logic [ADDRWIDTH:0]   aempty_thr,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 err_clr
);

    localparam int                 DEPTH   = 1 << ADDRWIDTH;
    localparam logic [ADDRWIDTH:0] DEPTH_L = DEPTH[ADDRWIDTH:0];
    localparam logic [ADDRWIDTH:0] ZERO_L  = {(ADDRWIDTH+1){1'b0}};

    logic [DATAWIDTH-1:0] ram [DEPTH];

    logic [ADDRWIDTH:0]   wptr_q, wptr_d;
    logic [ADDRWIDTH:0]   rptr_q, rptr_d;
    logic [ADDRWIDTH:0]   level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 winc_s;
    logic                 rinc_s;
    logic [ADDRWIDTH-1:0] waddr_s;
    logic [ADDRWIDTH-1:0] raddr_s;

    assign waddr_s = wptr_q[ADDRWIDTH-1:0];
    assign raddr_s = rptr_q[ADDRWIDTH-1:0];

    // Status is decoded from registered level only, never from the request inputs.
    assign full         = (level_q == DEPTH_L);
    assign empty        = (level_q == ZERO_L);
    assign level        = level_q;
    assign almost_full  = (level_q >= afull_thr);
    assign almost_empty = (level_q <= aempty_thr);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Accept decisions; a full FIFO still takes a write when a read retires a word.
    always_comb begin
        rinc_s = 1'b0;
        winc_s = 1'b0;
        if (!flush_i) begin
            rinc_s = r_en & ~empty;
            winc_s = w_en & (~full | rinc_s);
        end else begin
            rinc_s = 1'b0;
            winc_s = 1'b0;
        end
    end

    // Next-state for pointers, level and sticky flags (a set beats a same-cycle clear).
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q & ~err_clr;
        udf_d   = udf_q & ~err_clr;
        if (flush_i) begin
            wptr_d  = ZERO_L;
            rptr_d  = ZERO_L;
            level_d = ZERO_L;
            ovf_d   = ovf_q;
            udf_d   = udf_q;
        end else begin
            wptr_d  = wptr_q + {{ADDRWIDTH{1'b0}}, winc_s};
            rptr_d  = rptr_q + {{ADDRWIDTH{1'b0}}, rinc_s};
            level_d = level_q + {{ADDRWIDTH{1'b0}}, winc_s} - {{ADDRWIDTH{1'b0}}, rinc_s};
            ovf_d   = (ovf_q & ~err_clr) | (w_en & ~winc_s);
            udf_d   = (udf_q & ~err_clr) | (r_en & ~rinc_s);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            wptr_q  <= ZERO_L;
            rptr_q  <= ZERO_L;
            level_q <= ZERO_L;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (rst_n && winc_s) begin
            ram[waddr_s] <= DataIn;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATAWIDTH-1:0] dout_q, dout_d;

            // Read data register loads only on an accepted read.
            always_comb begin
                dout_d = dout_q;
                if (flush_i) begin
                    dout_d = {DATAWIDTH{1'b0}};
                end else if (rinc_s) begin
                    dout_d = ram[raddr_s];
                end else begin
                    dout_d = dout_q;
                end
            end

            // Output register with synchronous active-low reset.
            always_ff @(posedge clk_i) begin
                if (!rst_n) begin
                    dout_q <= {DATAWIDTH{1'b0}};
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign DataOut = dout_q;
        end else begin : g_show_ahead
            assign DataOut = empty ? {DATAWIDTH{1'b0}} : ram[raddr_s];
        end
    endgenerate

endmodule
